// File: rtl/burst_read_master.sv
`default_nettype none
// ============================================================================
// Module      : burst_read_master
// Description : Avalon-MM burst read master. Fetches ctrl_length words from
//               ctrl_baseaddress in bursts of at most BURST_COUNT beats and
//               buffers them in a show-ahead FIFO drained through a
//               valid/read user port. A burst is only requested once the
//               FIFO can absorb all of its beats, so the user may stall.
//               Optional build macro BURST_READ_CHECK_EN adds a data compare
//               against ctrl_pattern with a saturating mismatch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_read_master #(
  parameter int ADDRESS_WIDTH     = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int BYTE_ENABLE_WIDTH = 4,
  parameter int LENGTH_WIDTH      = 16,
  parameter int BURST_COUNT       = 4,
  parameter int BURST_WIDTH       = 3,
  parameter int FIFO_DEPTH        = 16,
  parameter int FIFO_DEPTH_LOG2   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  // Avalon-MM read master
  output logic [ADDRESS_WIDTH-1:0]     master_address,
  output logic                         master_read,
  output logic [BURST_WIDTH-1:0]       master_burstcount,
  output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
  input  logic                         master_waitrequest,
  input  logic [DATA_WIDTH-1:0]        master_readdata,
  input  logic                         master_readdatavalid,
  // Control
  input  logic                         ctrl_start,
  input  logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress,
  input  logic [LENGTH_WIDTH-1:0]      ctrl_length,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
`ifdef BURST_READ_CHECK_EN
  input  logic [DATA_WIDTH-1:0]        ctrl_pattern,
  output logic [LENGTH_WIDTH-1:0]      ctrl_mismatch,
`endif
  // User read port
  output logic [DATA_WIDTH-1:0]        user_data,
  output logic                         user_valid,
  input  logic                         user_read
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = FIFO_DEPTH_LOG2 + 1;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_WAITSPACE = 3'd1;
  localparam logic [2:0] c_ST_REQ       = 3'd2;
  localparam logic [2:0] c_ST_DATA      = 3'd3;
  localparam logic [2:0] c_ST_DONE      = 3'd4;

  localparam logic [CNT_W-1:0]        c_FIFO_DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]        c_BURST_ROOM = CNT_W'(BURST_COUNT);
  localparam logic [LENGTH_WIDTH-1:0] c_BURST_LEN  = LENGTH_WIDTH'(BURST_COUNT);
  localparam logic [ADDRESS_WIDTH-1:0] c_WORD_BYTES = ADDRESS_WIDTH'(BYTE_ENABLE_WIDTH);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [2:0]                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]     addr_q, addr_d;
  logic [LENGTH_WIDTH-1:0]      remaining_q, remaining_d;
  logic [BURST_WIDTH-1:0]       beats_left_q, beats_left_d;
  logic                         read_q, read_d;
  logic [ADDRESS_WIDTH-1:0]     address_q, address_d;
  logic [BURST_WIDTH-1:0]       burstcount_q, burstcount_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic [BYTE_ENABLE_WIDTH-1:0] byteenable_q;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]        mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]   wr_ptr_q;
  logic [FIFO_DEPTH_LOG2-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]             count_q;

  // Combinational helpers
  logic                         w_start;
  logic                         w_room;
  logic [CNT_W-1:0]             w_free;
  logic [BURST_WIDTH-1:0]       w_burst_len;
  logic                         w_accept;
  logic                         w_last_beat;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_full;
  logic                         w_wr_en;

  assign w_start  = (state_q == c_ST_IDLE) && ctrl_start;
  // Nothing is outstanding while waiting for space, so the FIFO count alone
  // is the fill level.
  assign w_free   = c_FIFO_DEPTH - count_q;
  assign w_room   = (w_free >= c_BURST_ROOM);
  // Final burst is exactly the words left; all others are full length.
  assign w_burst_len = (remaining_q >= c_BURST_LEN) ? BURST_WIDTH'(BURST_COUNT)
                                                    : BURST_WIDTH'(remaining_q);
  assign w_accept    = (state_q == c_ST_REQ) && !master_waitrequest;
  // Beats only count in DATA; anything earlier is a stray and dropped.
  assign w_push      = (state_q == c_ST_DATA) && master_readdatavalid;
  assign w_last_beat = w_push && (beats_left_q == BURST_WIDTH'(1));

  assign w_full  = (count_q == c_FIFO_DEPTH);
  assign w_pop   = user_read && (count_q != '0);
  // A full FIFO can still take a beat when the head leaves on the same edge.
  assign w_wr_en = w_push && (!w_full || w_pop);

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (ctrl_start) begin
          state_d = (ctrl_length == '0) ? c_ST_DONE : c_ST_WAITSPACE;
        end
      end
      c_ST_WAITSPACE: begin
        if (w_room) begin
          state_d = c_ST_REQ;
        end
      end
      c_ST_REQ: begin
        if (!master_waitrequest) begin
          state_d = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_last_beat) begin
          state_d = (remaining_q == '0) ? c_ST_DONE : c_ST_WAITSPACE;
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  // Next values for the registered bus outputs, status and transfer counters.
  always_comb begin
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    beats_left_d = beats_left_q;
    read_d       = read_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (ctrl_start) begin
          addr_d      = ctrl_baseaddress;
          remaining_d = ctrl_length;
          busy_d      = 1'b1;
        end
      end
      c_ST_WAITSPACE: begin
        if (w_room) begin
          read_d       = 1'b1;
          address_d    = addr_q;
          burstcount_d = w_burst_len;
        end
      end
      c_ST_REQ: begin
        // Request stays frozen until the slave takes it.
        if (w_accept) begin
          read_d       = 1'b0;
          beats_left_d = burstcount_q;
          addr_d       = addr_q + (ADDRESS_WIDTH'(burstcount_q) * c_WORD_BYTES);
          remaining_d  = remaining_q - LENGTH_WIDTH'(burstcount_q);
        end
      end
      c_ST_DATA: begin
        if (w_push) begin
          beats_left_d = beats_left_q - BURST_WIDTH'(1);
        end
      end
      c_ST_DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: begin
        read_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      beats_left_q <= '0;
      read_q       <= 1'b0;
      address_q    <= '0;
      burstcount_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      byteenable_q <= '0;
    end else begin
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      beats_left_q <= beats_left_d;
      read_q       <= read_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      byteenable_q <= '1;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  // Storage array; left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[wr_ptr_q] <= master_readdata;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_wr_en) begin
        wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
      end
      if (w_wr_en && !w_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (w_pop && !w_wr_en) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

`ifdef BURST_READ_CHECK_EN
  // --------------------------------------------------------------------------
  // Loopback data check
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   pattern_q;
  logic [LENGTH_WIDTH-1:0] mismatch_q;

  // Pattern capture and saturating mismatch count over every pushed beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q  <= '0;
      mismatch_q <= '0;
    end else if (w_start) begin
      pattern_q  <= ctrl_pattern;
      mismatch_q <= '0;
    end else if (w_push && (master_readdata != pattern_q) && (mismatch_q != '1)) begin
      mismatch_q <= mismatch_q + LENGTH_WIDTH'(1);
    end
  end

  assign ctrl_mismatch = mismatch_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign master_address    = address_q;
  assign master_read       = read_q;
  assign master_burstcount = burstcount_q;
  assign master_byteenable = byteenable_q;
  assign ctrl_busy         = busy_q;
  assign ctrl_done         = done_q;
  assign user_valid        = (count_q != '0);
  // Head is masked to zero while empty so a flushed FIFO shows no stale data.
  assign user_data         = user_valid ? mem_q[rd_ptr_q] : '0;

`ifndef SYNTHESIS
  // A beat arriving with no free slot means the space check was bypassed.
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
                                   !(w_push && w_full && !w_pop));
`endif

endmodule
`default_nettype wire

// File: tb/tb_burst_read_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_burst_read_master
// Description : Self-checking bench for burst_read_master. A randomized
//               Avalon slave returns data, a reference plan of bursts is
//               derived from base/length arithmetic, and a scoreboard queue
//               is compared against the user port as words are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_read_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BEW = 4;
  localparam int LW  = 16;
  localparam int BC  = 4;
  localparam int BW  = 3;
  localparam int FD  = 16;
  localparam int FDL = 4;
  localparam logic [DW-1:0] PATTERN = 32'h55667788;
  localparam int BIG = 1 << 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [AW-1:0]  master_address;
  logic           master_read;
  logic [BW-1:0]  master_burstcount;
  logic [BEW-1:0] master_byteenable;
  logic           master_waitrequest;
  logic [DW-1:0]  master_readdata;
  logic           master_readdatavalid;
  logic           ctrl_start;
  logic [AW-1:0]  ctrl_baseaddress;
  logic [LW-1:0]  ctrl_length;
  logic           ctrl_busy;
  logic           ctrl_done;
  logic [DW-1:0]  user_data;
  logic           user_valid;
  logic           user_read;
`ifdef BURST_READ_CHECK_EN
  logic [DW-1:0]  ctrl_pattern;
  logic [LW-1:0]  ctrl_mismatch;
`endif

  burst_read_master #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_ENABLE_WIDTH(BEW),
    .LENGTH_WIDTH(LW), .BURST_COUNT(BC), .BURST_WIDTH(BW),
    .FIFO_DEPTH(FD), .FIFO_DEPTH_LOG2(FDL)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .master_address      (master_address),
    .master_read         (master_read),
    .master_burstcount   (master_burstcount),
    .master_byteenable   (master_byteenable),
    .master_waitrequest  (master_waitrequest),
    .master_readdata     (master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .ctrl_start          (ctrl_start),
    .ctrl_baseaddress    (ctrl_baseaddress),
    .ctrl_length         (ctrl_length),
    .ctrl_busy           (ctrl_busy),
    .ctrl_done           (ctrl_done),
`ifdef BURST_READ_CHECK_EN
    .ctrl_pattern        (ctrl_pattern),
    .ctrl_mismatch       (ctrl_mismatch),
`endif
    .user_data           (user_data),
    .user_valid          (user_valid),
    .user_read           (user_read)
  );

  // Scoreboard and reference burst plan
  logic [DW-1:0] exp_data[$];
  logic [AW-1:0] exp_baddr[$];
  int            exp_bcnt[$];

  int checks = 0;
  int fails  = 0;

  // Knobs written by the main sequence only
  int wait_pct     = 0;
  int rdv_pct      = 100;
  int read_pct     = 100;
  int beat_limit   = BIG;
  int stray_target = 0;
  int pop_limit    = BIG;
  int hold_req_idx = -1;
  int hold_cycles  = 0;
  int pat_mode     = 0;
  int pat_base     = 0;

  // Counters written by the slave / monitor only
  int beats_sent = 0;
  int stray_sent = 0;
  int req_cnt    = 0;
  int stall_seen = 0;
  int pop_total  = 0;
  int done_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Avalon slave: decides waitrequest/readdatavalid for the next rising edge.
  initial begin : p_slave
    int pending;
    int held;
    logic wr;
    logic [DW-1:0] d;
    pending = 0;
    held    = 0;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pending = 0;
        held    = 0;
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b0;
        continue;
      end
      // Return data for bursts accepted on earlier edges.
      master_readdatavalid = 1'b0;
      if (stray_sent < stray_target) begin
        master_readdatavalid = 1'b1;
        master_readdata      = $urandom();
        stray_sent++;
      end else if (pending > 0 && beats_sent < beat_limit &&
                   int'($urandom_range(99)) < rdv_pct) begin
        if (pat_mode != 0)
          d = (beats_sent - pat_base == 2 || beats_sent - pat_base == 6) ? ~PATTERN : PATTERN;
        else
          d = $urandom();
        master_readdatavalid = 1'b1;
        master_readdata      = d;
        exp_data.push_back(d);
        pending--;
        beats_sent++;
      end
      // Request handshake.
      wr = (int'($urandom_range(99)) < wait_pct);
      if (master_read && req_cnt == hold_req_idx && held < hold_cycles) begin
        wr = 1'b1;
        held++;
      end
      master_waitrequest = wr;
      if (master_read) begin
        if (exp_baddr.size() == 0) begin
          check("req_unexpected", 64'(master_read), 64'd0);
        end else begin
          check("req_addr", 64'(master_address), 64'(exp_baddr[0]));
          check("req_bcnt", 64'(master_burstcount), 64'(exp_bcnt[0]));
          check("req_byteenable", 64'(master_byteenable), 64'hF);
          if (wr) begin
            stall_seen++;
          end else begin
            pending += exp_bcnt[0];
            void'(exp_baddr.pop_front());
            void'(exp_bcnt.pop_front());
            req_cnt++;
            held = 0;
          end
        end
      end
    end
  end

  // User-side monitor: pops the FIFO and compares against the scoreboard.
  initial begin : p_mon
    logic [DW-1:0] e;
    user_read = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_data.delete();
        user_read = 1'b0;
        continue;
      end
      if (ctrl_done) done_cnt++;
      user_read = (pop_total < pop_limit) && (int'($urandom_range(99)) < read_pct);
      if (user_read && user_valid) begin
        if (exp_data.size() == 0) begin
          check("pop_unexpected", 64'(user_valid), 64'd0);
        end else begin
          e = exp_data.pop_front();
          check("user_data", 64'(user_data), 64'(e));
        end
        pop_total++;
      end
    end
  end

  initial begin : p_watchdog
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input int len);
    for (int i = 0; i * BC < len; i++) begin
      exp_baddr.push_back(base + AW'(i * BC * BEW));
      exp_bcnt.push_back((len - i * BC) < BC ? (len - i * BC) : BC);
    end
    ctrl_baseaddress = base;
    ctrl_length      = LW'(len);
    ctrl_start       = 1'b1;
    tick();
    ctrl_start       = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int len, input int s0, input int d0);
    int n;
    n = 0;
    while (ctrl_done !== 1'b1 && n < 4000) begin tick(); n++; end
    check({tag, "_done_seen"}, 64'(ctrl_done), 64'd1);
    tick();
    check({tag, "_busy_clear"}, 64'(ctrl_busy), 64'd0);
    check({tag, "_all_bursts"}, 64'(exp_baddr.size()), 64'd0);
    check({tag, "_beats"}, 64'(beats_sent - s0), 64'(len));
    n = 0;
    while ((exp_data.size() != 0 || user_valid) && n < 4000) begin tick(); n++; end
    check({tag, "_drained"}, 64'(exp_data.size()), 64'd0);
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_read"}, 64'(master_read), 64'd0);
    check({tag, "_addr"}, 64'(master_address), 64'd0);
    check({tag, "_bcnt"}, 64'(master_burstcount), 64'd0);
    check({tag, "_be"}, 64'(master_byteenable), 64'd0);
    check({tag, "_busy"}, 64'(ctrl_busy), 64'd0);
    check({tag, "_done"}, 64'(ctrl_done), 64'd0);
    check({tag, "_uvalid"}, 64'(user_valid), 64'd0);
    check({tag, "_udata"}, 64'(user_data), 64'd0);
  endtask

  initial begin : p_main
    int s0, d0, n, len;
    logic [AW-1:0] base;
    reset            = 1'b1;
    ctrl_start       = 1'b0;
    ctrl_baseaddress = '0;
    ctrl_length      = '0;
`ifdef BURST_READ_CHECK_EN
    ctrl_pattern     = PATTERN;
`endif
    repeat (3) tick();
    check_reset_outputs("rst");
`ifdef BURST_READ_CHECK_EN
    check("rst_mismatch", 64'(ctrl_mismatch), 64'd0);
`endif
    reset = 1'b0;
    repeat (2) tick();

    // T1: two full bursts, no stalls; checks request and data latency.
    wait_pct = 0; rdv_pct = 100; read_pct = 0;
    s0 = beats_sent; d0 = done_cnt;
    start_xfer(32'h3800_0000, 8);
    check("t1_busy", 64'(ctrl_busy), 64'd1);
    check("t1_read_early", 64'(master_read), 64'd0);
    tick();
    check("t1_read_latency", 64'(master_read), 64'd1);
    check("t1_first_addr", 64'(master_address), 64'h3800_0000);
    n = 0;
    while (beats_sent == s0 && n < 50) begin
      check("t1_uvalid_before", 64'(user_valid), 64'd0);
      tick(); n++;
    end
    check("t1_uvalid_latency", 64'(user_valid), 64'd1);
    if (exp_data.size() != 0) check("t1_first_word", 64'(user_data), 64'(exp_data[0]));
    read_pct = 100;
    finish_xfer("t1", 8, s0, d0);

    // T2: first request held off by waitrequest for 3 cycles.
    s0 = beats_sent; d0 = done_cnt; n = stall_seen;
    hold_req_idx = req_cnt; hold_cycles = 3;
    start_xfer(32'h0000_1000, 6);
    finish_xfer("t2", 6, s0, d0);
    check("t2_stalls", 64'(stall_seen - n), 64'd3);
    hold_req_idx = -1;

    // T3: user stalled; FIFO fills to depth then waits for 4 free slots.
    s0 = beats_sent; d0 = done_cnt;
    pop_limit = pop_total;
    start_xfer(32'h0002_0000, 32);
    repeat (60) tick();
    check("t3_accepted", 64'(beats_sent - s0), 64'(FD));
    check("t3_read_idle", 64'(master_read), 64'd0);
    check("t3_bursts_left", 64'(exp_baddr.size()), 64'd4);
    pop_limit = pop_total + 3;
    repeat (20) tick();
    check("t3_read_after3", 64'(master_read), 64'd0);
    check("t3_accepted_after3", 64'(beats_sent - s0), 64'(FD));
    pop_limit = pop_limit + 1;
    n = 0;
    while (master_read !== 1'b1 && n < 10) begin tick(); n++; end
    check("t3_read_after4", 64'(master_read), 64'd1);
    pop_limit = BIG;
    finish_xfer("t3", 32, s0, d0);

    // T4: zero-length transfer.
    s0 = beats_sent; d0 = done_cnt;
    start_xfer(32'h0000_0040, 0);
    check("t4_busy", 64'(ctrl_busy), 64'd1);
    check("t4_done_early", 64'(ctrl_done), 64'd0);
    tick();
    check("t4_done", 64'(ctrl_done), 64'd1);
    check("t4_busy_clear", 64'(ctrl_busy), 64'd0);
    tick();
    check("t4_done_pulse", 64'(ctrl_done), 64'd0);
    check("t4_no_read", 64'(master_read), 64'd0);
    check("t4_done_once", 64'(done_cnt - d0), 64'd1);

    // T5: reset in DATA with 2 beats outstanding, then stray beats.
    read_pct = 0;
    s0 = beats_sent;
    beat_limit = beats_sent + 2;
    start_xfer(32'h0000_2000, 8);
    n = 0;
    while (beats_sent - s0 < 2 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    reset = 1'b1;
    exp_baddr.delete();
    exp_bcnt.delete();
    repeat (2) tick();
    check_reset_outputs("t5");
    reset = 1'b0;
    beat_limit = BIG;
    stray_target = stray_sent + 2;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t5_uvalid_stray", 64'(user_valid), 64'd0);
    end
    check("t5_busy", 64'(ctrl_busy), 64'd0);
    read_pct = 100;

`ifdef BURST_READ_CHECK_EN
    // T6: pattern compare with beats 3 and 7 corrupted.
    wait_pct = 0; rdv_pct = 100;
    s0 = beats_sent; d0 = done_cnt;
    pat_base = beats_sent; pat_mode = 1;
    start_xfer(32'h0000_3000, 8);
    n = 0;
    while (ctrl_done !== 1'b1 && n < 500) begin tick(); n++; end
    check("t6_mismatch", 64'(ctrl_mismatch), 64'd2);
    tick();
    pat_mode = 0;
    n = 0;
    while ((exp_data.size() != 0 || user_valid) && n < 500) begin tick(); n++; end
`endif

    // Randomized transfers with random stalls on both sides.
    for (int t = 0; t < 6; t++) begin
      wait_pct = int'($urandom_range(50));
      rdv_pct  = 30 + int'($urandom_range(70));
      read_pct = 20 + int'($urandom_range(80));
      len      = 1 + int'($urandom_range(39));
      base     = $urandom() & 32'hFFFF_FFFC;
      s0 = beats_sent; d0 = done_cnt;
      start_xfer(base, len);
      finish_xfer($sformatf("rnd%0d", t), len, s0, d0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
